// File: rtl/wb_rr_arbiter_4.sv
// Round-robin Wishbone B3 classic arbiter: four masters share one slave port, owner keeps it for its whole cycle.
// Define WB_RR_ARBITER_TIMEOUT_EN to add a watchdog that errors out an access the slave never answers.
module wb_rr_arbiter_4 #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [3:0]                     m_cyc,
  input  logic [3:0]                     m_stb,
  input  logic [3:0]                     m_we,
  input  logic [4*WB_ADDR_WIDTH-1:0]     m_adr,
  input  logic [4*WB_DATA_WIDTH-1:0]     m_dat_w,
  input  logic [4*(WB_DATA_WIDTH/8)-1:0] m_sel,
  output logic [WB_DATA_WIDTH-1:0]       m_dat_r,
  output logic [3:0]                     m_ack,
  output logic [3:0]                     m_err,
  output logic                           s_cyc,
  output logic                           s_stb,
  output logic                           s_we,
  output logic [WB_ADDR_WIDTH-1:0]       s_adr,
  output logic [WB_DATA_WIDTH-1:0]       s_dat_w,
  output logic [(WB_DATA_WIDTH/8)-1:0]   s_sel,
  input  logic [WB_DATA_WIDTH-1:0]       s_dat_r,
  input  logic                           s_ack,
  input  logic                           s_err,
  output logic [3:0]                     gnt_o
);

  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned DW = WB_DATA_WIDTH;
  localparam int unsigned SW = WB_DATA_WIDTH / 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [1:0]    gnt, gnt_nxt;
  logic [1:0]    last, last_nxt;
  logic [1:0]    pick, cand;
  logic          owned;
  logic          fire;

  logic [AW-1:0] adr_a [4];
  logic [DW-1:0] dat_a [4];
  logic [SW-1:0] sel_a [4];

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign adr_a[i] = m_adr[i*AW +: AW];
    assign dat_a[i] = m_dat_w[i*DW +: DW];
    assign sel_a[i] = m_sel[i*SW +: SW];
  end

  assign owned   = (state == OWNED);
  assign m_dat_r = s_dat_r;

  // First requester after the previous owner; later scan steps override earlier ones.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (m_cyc[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd3;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_w   = '0;
    s_sel     = '0;
    m_ack     = '0;
    m_err     = '0;
    gnt_o     = '0;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nxt = OWNED;
          gnt_nxt   = pick;
        end
      end
      OWNED: begin
        s_cyc        = m_cyc[gnt] & ~fire;
        s_stb        = m_stb[gnt] & ~fire;
        s_we         = m_we[gnt];
        s_adr        = adr_a[gnt];
        s_dat_w      = dat_a[gnt];
        s_sel        = sel_a[gnt];
        m_ack[gnt]   = s_ack;
        m_err[gnt]   = s_err | fire;
        gnt_o[gnt]   = 1'b1;
        // Owner releases by dropping cyc; the IDLE visit guarantees a gap between owners.
        if (!m_cyc[gnt]) begin
          state_nxt = IDLE;
          last_nxt  = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign fire = owned && (cnt == CW'(TIMEOUT_CYCLES));

  // Counts unanswered strobe cycles; any response or the forced error restarts it.
  always_ff @(posedge clk) begin
    if (!rstn || !owned || s_ack || s_err || fire) begin
      cnt <= '0;
    end else if (s_cyc && s_stb) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;

  assign fire           = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

endmodule
